// File: rtl/sync_lock_det_pkg.sv
// Shared types and default widths for the frame-sync lock detector.
package sync_lock_det_pkg;

  localparam int ST_W  = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    VERIFY   = 2'd1,
    LOCK     = 2'd2,
    FLYWHEEL = 2'd3
  } sync_state_t;

endpackage

// File: rtl/sync_win_classify.sv
// Combinational good/bad window classifier; an inverted threshold pair makes every window bad.
module sync_win_classify
  import sync_lock_det_pkg::*;
#(
  parameter int pST_W = ST_W
) (
  input  logic [pST_W-1:0] istat,
  input  logic [pST_W-1:0] ithr_lo,
  input  logic [pST_W-1:0] ithr_hi,
  output logic             ogood
);

  assign ogood = (istat >= ithr_lo) && (istat <= ithr_hi);

endmodule

// File: rtl/sync_lock_det.sv
// Hysteresis lock detector (hunt / verify / lock / flywheel) driven by per-window peak counts.
module sync_lock_det
  import sync_lock_det_pkg::*;
#(
  parameter int pST_W  = ST_W,
  parameter int pCNT_W = CNT_W
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iena,
  input  logic              iclr,
  input  logic [pST_W-1:0]  istat,
  input  logic              ival,
  input  logic [pST_W-1:0]  ithr_lo,
  input  logic [pST_W-1:0]  ithr_hi,
  input  logic [pCNT_W-1:0] inum_acq,
  input  logic [pCNT_W-1:0] inum_lost,
  output logic              olock,
  output logic [1:0]        ostate,
  output logic              olock_pulse,
  output logic              olost_pulse,
  output logic [pST_W-1:0]  ostat_last
);

  localparam logic [pCNT_W-1:0] CNT_ONE = pCNT_W'(1);

  function automatic logic [pCNT_W-1:0] sat_inc(input logic [pCNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  sync_state_t       state_q, state_d;
  logic [pCNT_W-1:0] run_q, run_d;
  logic [pCNT_W-1:0] miss_q, miss_d;
  logic              lock_q, lock_d;
  logic              lock_pulse_q, lock_pulse_d;
  logic              lost_pulse_q, lost_pulse_d;
  logic [pST_W-1:0]  stat_q, stat_d;

  logic              good;
  logic [pCNT_W-1:0] run_inc;
  logic [pCNT_W-1:0] miss_inc;

  sync_win_classify #(.pST_W(pST_W)) u_classify (
    .istat   (istat),
    .ithr_lo (ithr_lo),
    .ithr_hi (ithr_hi),
    .ogood   (good)
  );

  assign run_inc  = sat_inc(run_q);
  assign miss_inc = sat_inc(miss_q);

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    miss_d       = miss_q;
    stat_d       = stat_q;
    lock_pulse_d = 1'b0;
    lost_pulse_d = 1'b0;

    // Soft clear outranks the strobe; a disabled block ignores both.
    if (iena && iclr) begin
      state_d      = HUNT;
      run_d        = '0;
      miss_d       = '0;
      lost_pulse_d = (state_q == LOCK) || (state_q == FLYWHEEL);
    end else if (iena && ival) begin
      stat_d = istat;
      unique case (state_q)
        HUNT: begin
          if (good && (inum_acq <= CNT_ONE)) begin
            state_d      = LOCK;
            run_d        = '0;
            lock_pulse_d = 1'b1;
          end else if (good) begin
            state_d = VERIFY;
            run_d   = CNT_ONE;
          end
        end
        VERIFY: begin
          if (!good) begin
            state_d = HUNT;
            run_d   = '0;
          end else if (run_inc >= inum_acq) begin
            state_d      = LOCK;
            run_d        = '0;
            lock_pulse_d = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        LOCK: begin
          if (!good && (inum_lost <= CNT_ONE)) begin
            state_d      = HUNT;
            miss_d       = '0;
            lost_pulse_d = 1'b1;
          end else if (!good) begin
            state_d = FLYWHEEL;
            miss_d  = CNT_ONE;
          end
        end
        FLYWHEEL: begin
          if (good) begin
            state_d = LOCK;
            miss_d  = '0;
          end else if (miss_inc >= inum_lost) begin
            state_d      = HUNT;
            miss_d       = '0;
            lost_pulse_d = 1'b1;
          end else begin
            miss_d = miss_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    lock_d = (state_d == LOCK) || (state_d == FLYWHEEL);
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q      <= HUNT;
      run_q        <= '0;
      miss_q       <= '0;
      lock_q       <= 1'b0;
      lock_pulse_q <= 1'b0;
      lost_pulse_q <= 1'b0;
      stat_q       <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      miss_q       <= miss_d;
      lock_q       <= lock_d;
      lock_pulse_q <= lock_pulse_d;
      lost_pulse_q <= lost_pulse_d;
      stat_q       <= stat_d;
    end
  end

  assign olock       = lock_q;
  assign ostate      = state_q;
  assign olock_pulse = lock_pulse_q;
  assign olost_pulse = lost_pulse_q;
  assign ostat_last  = stat_q;

endmodule

// File: tb/tb_sync_lock_det.sv
// Table vectors, hand sequences and a streak-based random reference for sync_lock_det.
module tb_sync_lock_det;

  logic       iclk = 1'b0;
  logic       ireset;
  logic       iena;
  logic       iclr;
  logic [7:0] istat;
  logic       ival;
  logic [7:0] ithr_lo;
  logic [7:0] ithr_hi;
  logic [3:0] inum_acq;
  logic [3:0] inum_lost;
  logic       olock;
  logic [1:0] ostate;
  logic       olock_pulse;
  logic       olost_pulse;
  logic [7:0] ostat_last;

  int n_vec = 0;
  int n_err = 0;

  sync_lock_det #(.pST_W(8), .pCNT_W(4)) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .iena        (iena),
    .iclr        (iclr),
    .istat       (istat),
    .ival        (ival),
    .ithr_lo     (ithr_lo),
    .ithr_hi     (ithr_hi),
    .inum_acq    (inum_acq),
    .inum_lost   (inum_lost),
    .olock       (olock),
    .ostate      (ostate),
    .olock_pulse (olock_pulse),
    .olost_pulse (olost_pulse),
    .ostat_last  (ostat_last)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic       ena, clr, val;
    logic [7:0] stat, lo, hi;
    logic [3:0] acq, lost;
    logic [1:0] st;
    logic       lk, lp, lsp;
    logic [7:0] last;
  } vec_t;

  vec_t tbl[$];

  // Reference model: "locked" flag plus one streak count of consecutive
  // windows pushing toward the opposite condition.
  int  m_locked, m_streak, m_last, m_lp, m_lsp;

  task automatic add(input logic ena, clr, val, input logic [7:0] stat, lo, hi,
                     input logic [3:0] acq, lost, input logic [1:0] st,
                     input logic lk, lp, lsp, input logic [7:0] last);
    vec_t v;
    v.ena = ena; v.clr = clr; v.val = val; v.stat = stat; v.lo = lo; v.hi = hi;
    v.acq = acq; v.lost = lost; v.st = st; v.lk = lk; v.lp = lp; v.lsp = lsp;
    v.last = last;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic ena, clr, val, input logic [7:0] stat, lo, hi,
                       input logic [3:0] acq, lost);
    iena = ena; iclr = clr; ival = val; istat = stat;
    ithr_lo = lo; ithr_hi = hi; inum_acq = acq; inum_lost = lost;
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic lk, lp, lsp,
                       input logic [7:0] last);
    n_vec++;
    if (ostate !== st || olock !== lk || olock_pulse !== lp || olost_pulse !== lsp ||
        ostat_last !== last) begin
      n_err++;
      $display("FAIL %s: got state=%0d lock=%0b lp=%0b lostp=%0b last=%0d, want state=%0d lock=%0b lp=%0b lostp=%0b last=%0d",
               name, ostate, olock, olock_pulse, olost_pulse, ostat_last,
               st, lk, lp, lsp, last);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_streak = 0; m_last = 0; m_lp = 0; m_lsp = 0;
  endtask

  task automatic model_step(input logic ena, clr, val, input int stat, lo, hi, acq, lost);
    bit good;
    good  = (stat >= lo) && (stat <= hi);
    m_lp  = 0;
    m_lsp = 0;
    if (ena && clr) begin
      m_lsp    = m_locked;
      m_locked = 0;
      m_streak = 0;
    end else if (ena && val) begin
      m_last = stat;
      if (!m_locked) begin
        if (good) begin
          m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
          if (m_streak >= acq) begin
            m_locked = 1; m_streak = 0; m_lp = 1;
          end
        end else begin
          m_streak = 0;
        end
      end else begin
        if (good) begin
          m_streak = 0;
        end else begin
          m_streak = (m_streak + 1 > 15) ? 15 : m_streak + 1;
          if (m_streak >= lost) begin
            m_locked = 0; m_streak = 0; m_lsp = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_locked != 0) return (m_streak > 0) ? 2'd3 : 2'd2;
    return (m_streak > 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic async_reset();
    #3 ireset = 1'b0;
    #1 check("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge iclk) ireset = 1'b1;
  endtask

  initial begin
    ireset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0);
    #3 check("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge iclk) ireset = 1'b1;

    //   ena clr val stat lo  hi  acq lost | st lk lp lsp last
    add(1, 0, 1, 4, 3, 5, 3, 2, 1, 0, 0, 0, 4);
    add(1, 0, 1, 4, 3, 5, 3, 2, 1, 0, 0, 0, 4);
    add(1, 0, 1, 4, 3, 5, 3, 2, 2, 1, 1, 0, 4);
    add(1, 0, 0, 4, 3, 5, 3, 2, 2, 1, 0, 0, 4);
    add(1, 0, 1, 1, 3, 5, 3, 2, 3, 1, 0, 0, 1);
    add(1, 0, 1, 4, 3, 5, 3, 2, 2, 1, 0, 0, 4);
    add(1, 0, 1, 1, 3, 5, 3, 2, 3, 1, 0, 0, 1);
    add(1, 0, 1, 1, 3, 5, 3, 2, 0, 0, 0, 1, 1);
    add(1, 0, 0, 1, 3, 5, 3, 2, 0, 0, 0, 0, 1);
    add(1, 0, 1, 4, 3, 5, 3, 2, 1, 0, 0, 0, 4);
    add(1, 0, 1, 4, 3, 5, 3, 2, 1, 0, 0, 0, 4);
    add(1, 0, 1, 7, 3, 5, 3, 2, 0, 0, 0, 0, 7);
    add(1, 0, 1, 4, 3, 5, 3, 2, 1, 0, 0, 0, 4);
    add(1, 0, 1, 4, 3, 5, 3, 2, 1, 0, 0, 0, 4);
    add(1, 0, 1, 4, 3, 5, 3, 2, 2, 1, 1, 0, 4);
    add(1, 1, 1, 5, 3, 5, 3, 2, 0, 0, 0, 1, 4);
    add(1, 0, 0, 5, 3, 5, 3, 2, 0, 0, 0, 0, 4);
    add(0, 0, 1, 4, 3, 5, 3, 2, 0, 0, 0, 0, 4);
    add(0, 0, 1, 4, 3, 5, 3, 2, 0, 0, 0, 0, 4);
    add(1, 0, 1, 4, 3, 5, 0, 1, 2, 1, 1, 0, 4);
    add(1, 0, 1, 9, 3, 5, 0, 1, 0, 0, 0, 1, 9);
    add(1, 0, 1, 4, 6, 2, 0, 1, 0, 0, 0, 0, 4);
    add(1, 0, 1, 6, 6, 2, 0, 1, 0, 0, 0, 0, 6);
    add(1, 0, 1, 2, 6, 2, 0, 1, 0, 0, 0, 0, 2);
    add(1, 0, 1, 4, 4, 4, 1, 2, 2, 1, 1, 0, 4);
    add(1, 0, 1, 5, 4, 4, 1, 2, 3, 1, 0, 0, 5);
    add(0, 0, 1, 5, 4, 4, 1, 2, 3, 1, 0, 0, 5);
    add(1, 0, 1, 3, 4, 4, 1, 2, 0, 0, 0, 1, 3);

    foreach (tbl[i]) begin
      drive(tbl[i].ena, tbl[i].clr, tbl[i].val, tbl[i].stat, tbl[i].lo, tbl[i].hi,
            tbl[i].acq, tbl[i].lost);
      @(posedge iclk);
      #1 check($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].lk, tbl[i].lp, tbl[i].lsp,
               tbl[i].last);
    end

    // Enter FLYWHEEL, then pull reset between clock edges.
    drive(1, 0, 1, 8'd4, 8'd3, 8'd5, 4'd1, 4'd3);
    @(posedge iclk);
    #1 check("fw_lock", 2'd2, 1'b1, 1'b1, 1'b0, 8'd4);
    drive(1, 0, 1, 8'd0, 8'd3, 8'd5, 4'd1, 4'd3);
    @(posedge iclk);
    #1 check("fw_enter", 2'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(1, 0, 0, 8'd0, 8'd3, 8'd5, 4'd3, 4'd3);
    async_reset();
    drive(1, 0, 1, 8'd4, 8'd3, 8'd5, 4'd3, 4'd3);
    @(posedge iclk);
    #1 check("resume_hunt", 2'd1, 1'b0, 1'b0, 1'b0, 8'd4);
    drive(1, 0, 0, 8'd4, 8'd3, 8'd5, 4'd3, 4'd3);

    // Random phase against the streak model.
    async_reset();
    model_reset();
    begin
      logic       r_ena, r_clr, r_val;
      logic [7:0] r_stat, r_lo, r_hi;
      logic [3:0] r_acq, r_lost;
      r_lo = 8'd3; r_hi = 8'd8; r_acq = 4'd3; r_lost = 4'd2;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 49) == 0) begin
          r_lo   = 8'($urandom_range(0, 6));
          r_hi   = 8'($urandom_range(2, 12));
          r_acq  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
          r_lost = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        end
        r_ena  = ($urandom_range(0, 9) != 0);
        r_clr  = ($urandom_range(0, 39) == 0);
        r_val  = ($urandom_range(0, 3) != 0);
        r_stat = 8'($urandom_range(0, 12));
        model_step(r_ena, r_clr, r_val, int'(r_stat), int'(r_lo), int'(r_hi),
                   int'(r_acq), int'(r_lost));
        drive(r_ena, r_clr, r_val, r_stat, r_lo, r_hi, r_acq, r_lost);
        @(posedge iclk);
        #1 check($sformatf("rand[%0d]", i), model_state(), m_locked != 0, m_lp != 0,
                 m_lsp != 0, 8'(m_last));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sync_lock_det.md
Name: sync_lock_det

Overview:
Frame-sync lock detector placed directly downstream of the per-window peak statistics stage. Each statistics window reports how many sync peaks fell inside it. This block classifies each window as good or bad and runs a hysteresis state machine (hunt / verify / lock / flywheel). It produces a stable lock flag and one-cycle lock/lost event pulses for the demodulator control logic.

Parameters:
pST_W, 8, width of the per-window peak count (istat) and of the thresholds
pCNT_W, 4, width of the consecutive-window counters and the acquire/lose count inputs

Ports:
iclk  input  1  system clock
ireset  input  1  asynchronous reset, active-low
iena  input  1  block enable; when low, ival is ignored and all state is held
iclr  input  1  synchronous soft clear to HUNT; priority over ival
istat  input  pST_W  peak count of the completed window (unsigned)
ival  input  1  one-cycle strobe; istat is valid on this cycle
ithr_lo  input  pST_W  minimum peaks for a good window (inclusive)
ithr_hi  input  pST_W  maximum peaks for a good window (inclusive)
inum_acq  input  pCNT_W  consecutive good windows required to declare lock
inum_lost  input  pCNT_W  consecutive bad windows required to drop lock
olock  output  1  1 in LOCK and FLYWHEEL
ostate  output  2  current state: HUNT=0, VERIFY=1, LOCK=2, FLYWHEEL=3
olock_pulse  output  1  one-cycle pulse on the transition into LOCK from HUNT or VERIFY
olost_pulse  output  1  one-cycle pulse on the transition from LOCK or FLYWHEEL into HUNT
ostat_last  output  pST_W  istat captured on the last accepted ival

Behaviour:
- Reset (ireset low, async): state HUNT, run_cnt=0, miss_cnt=0, olock=0, ostate=0, both pulses 0, ostat_last=0.
- Accepted window: ival=1 and iena=1 and iclr=0. Any other ival is dropped with no effect.
- good = (istat >= ithr_lo) and (istat <= ithr_hi), unsigned compare. If ithr_lo > ithr_hi, every window is bad.
- All outputs are registered. State, olock, pulses and ostat_last update on the clock edge that samples the accepted ival, so they are visible the cycle after the strobe.
- HUNT:
  - good and inum_acq <= 1 -> LOCK, olock_pulse.
  - good otherwise -> VERIFY, run_cnt=1.
  - bad -> stay in HUNT.
- VERIFY:
  - good -> run_cnt+1. If the new value >= inum_acq -> LOCK, olock_pulse, run_cnt=0.
  - bad -> HUNT, run_cnt=0.
- LOCK:
  - good -> stay in LOCK.
  - bad and inum_lost <= 1 -> HUNT, olost_pulse.
  - bad otherwise -> FLYWHEEL, miss_cnt=1.
- FLYWHEEL:
  - good -> LOCK, miss_cnt=0. No olock_pulse.
  - bad -> miss_cnt+1. If the new value >= inum_lost -> HUNT, olost_pulse, miss_cnt=0.
- Counters saturate at 2^pCNT_W-1; they never wrap.
- inum_acq and inum_lost are sampled per accepted window; a change mid-run takes effect on the next comparison.
- iclr=1: next edge forces HUNT and zeroes both counters. olost_pulse fires if the prior state was LOCK or FLYWHEEL. ostat_last is kept.
- Pulses are 0 on every cycle without a transition. Back-to-back ival on consecutive cycles must be handled, one decision per cycle.
- iena low mid-run: state and counters frozen, outputs hold their values, pulses 0.

Decomposition:
- Shared sync package holds:
  - typedef enum logic [1:0] sync_state_t {HUNT, VERIFY, LOCK, FLYWHEEL};
  - default widths ST_W=8 and CNT_W=4.
- Optional sub-module sync_win_classify (registered-free comparator: istat, ithr_lo, ithr_hi -> good).
- The FSM and counters stay in sync_lock_det.

Test Plan:
- Reset then ithr_lo=3, ithr_hi=5, inum_acq=3, inum_lost=2; three ival with istat=4 -> ostate 0->1->1->2. olock=1 and olock_pulse=1 for exactly one cycle after the third strobe.
- From VERIFY (two good windows), istat=7 (above hi) -> HUNT, run_cnt=0. Three further good windows are then needed to lock.
- In LOCK, istat=1, 4, 1, 1 -> LOCK->FLYWHEEL->LOCK->FLYWHEEL->HUNT. olock stays 1 until the final window; olost_pulse=1 once; no olock_pulse on the FLYWHEEL->LOCK recovery.
- inum_acq=0 and inum_lost=1: a single good window locks immediately; a single bad window drops to HUNT. ithr_lo=6, ithr_hi=2: no window is ever good, so the block stays in HUNT.
- iena=0 with ival pulses -> no state change. In LOCK, iclr=1 together with ival and a good istat -> HUNT, olost_pulse=1, ostat_last unchanged.
- Assert ireset asynchronously mid-FLYWHEEL, off a clock edge -> all outputs 0 immediately. After release, the block resumes from HUNT.
